// File: rtl/mac_pkg.sv
// Shared FP32 field constants, the exact-product record and accumulator sizing
// helpers for the multi-lane exact accumulator.
package mac_pkg;

   localparam int FP_EXP_W  = 8;
   localparam int FP_FRAC_W = 23;
   localparam int FP_MANT_W = FP_FRAC_W + 1;
   localparam int BIAS      = 127;
   localparam int PROD_W    = 2 * FP_MANT_W;

   typedef struct packed {
      logic        sign;
      logic [8:0]  exp;
      logic [47:0] mant;
   } product_t;

   function automatic int reg_size(input int words, input int wsize);
      return words * wsize;
   endfunction

   function automatic int frac_bits(input int words, input int wsize);
      return reg_size(words, wsize) / 2;
   endfunction

endpackage

// File: rtl/fp_product_aligner.sv
// One lane: registers the exact FP32 product, then places it as a two's-complement
// fixed-point word in which bit k weighs 2^(k-FRAC_BITS).
module fp_product_aligner
   import mac_pkg::*;
#(
   parameter int REG_SIZE  = 1024,
   parameter int FRAC_BITS = 512
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                adv_i,
   input  logic [31:0]         a_i,
   input  logic [31:0]         b_i,
   input  logic                en_i,
   output logic                nan_o,
   output logic [REG_SIZE-1:0] aligned_o
);

   // Product LSB weighs 2^(Ea+Eb-2*BIAS-46); shift that onto the fixed-point grid.
   localparam int OFFS = FRAC_BITS - 2 * BIAS - (PROD_W - 2);

   logic [7:0]          ea, eb;
   product_t            prod_d, prod_q;
   logic                nan_d, nan_q;
   logic signed [31:0]  shift;
   logic [REG_SIZE-1:0] mag;

   always_comb begin
      ea     = a_i[30:23];
      eb     = b_i[30:23];
      nan_d  = en_i && (ea == '1 || eb == '1);
      prod_d = '0;
      if (en_i && ea != '0 && eb != '0) begin
         prod_d.sign = a_i[31] ^ b_i[31];
         prod_d.exp  = {1'b0, ea} + {1'b0, eb};
         prod_d.mant = {24'b0, 1'b1, a_i[22:0]} * {24'b0, 1'b1, b_i[22:0]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prod_q <= '0;
         nan_q  <= 1'b0;
      end else if (adv_i) begin
         prod_q <= prod_d;
         nan_q  <= nan_d;
      end
   end

   always_comb begin
      shift = 32'(prod_q.exp) + OFFS;
      mag   = '0;
      mag[PROD_W-1:0] = prod_q.mant;
      if (shift >= 0) mag = mag << shift;
      else            mag = mag >> (-shift);
      aligned_o = prod_q.sign ? -mag : mag;
   end

   assign nan_o = nan_q;

endmodule

// File: rtl/multi_lane_exact_accumulator.sv
// Exact fixed-point dot-product accumulator over FP32 lanes with a rounded FP32
// frame result; four pipeline stages sharing one global stall.
module multi_lane_exact_accumulator
   import mac_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int REG_WORDS = 128,
   parameter int WORD_SIZE = 8
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               InValid,
   output logic               InReady,
   input  logic               InFirst,
   input  logic               InLast,
   input  logic [LANES*32-1:0] In1,
   input  logic [LANES*32-1:0] In2,
   input  logic [LANES-1:0]   LaneMask,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [31:0]        Out,
   output logic               OutOverflow
);

   localparam int REG_SIZE  = reg_size(REG_WORDS, WORD_SIZE);
   localparam int FRAC_BITS = frac_bits(REG_WORDS, WORD_SIZE);

   logic                adv;
   logic                v1_q, first1_q, last1_q;
   logic                v2_q, first2_q, last2_q, nan2_q;
   logic                v3_q;
   logic [REG_SIZE-1:0] aligned [LANES];
   logic [LANES-1:0]    lane_nan;
   logic [REG_SIZE-1:0] sum_d, sum2_q, acc_d, acc_q;
   logic                nan_d, nan_q;
   logic                out_valid_q, ovf_q, ovf_d;
   logic [31:0]         out_q, out_d;

   assign adv         = !(out_valid_q && !OutReady);
   assign InReady     = adv;
   assign OutValid    = out_valid_q;
   assign Out         = out_q;
   assign OutOverflow = ovf_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fp_product_aligner #(
         .REG_SIZE (REG_SIZE),
         .FRAC_BITS(FRAC_BITS)
      ) u_lane (
         .clk_i    (Clk),
         .rst_i    (Rst),
         .adv_i    (adv),
         .a_i      (In1[32*i +: 32]),
         .b_i      (In2[32*i +: 32]),
         .en_i     (LaneMask[i]),
         .nan_o    (lane_nan[i]),
         .aligned_o(aligned[i])
      );
   end

   always_comb begin
      sum_d = '0;
      for (int unsigned i = 0; i < LANES; i++) sum_d = sum_d + aligned[i];
   end

   always_comb begin
      acc_d = acc_q;
      nan_d = nan_q;
      if (v2_q) begin
         acc_d = first2_q ? sum2_q : acc_q + sum2_q;
         nan_d = first2_q ? nan2_q : (nan_q | nan2_q);
      end
   end

   logic [REG_SIZE-1:0] mag, norm;
   logic [31:0]         lead;
   logic                guard, sticky, rnd_up;
   logic [23:0]         mant_rnd;
   logic signed [31:0]  exp_n;

   // Normalise so the leading one sits at the MSB; bits below it feed RNE.
   always_comb begin
      mag  = acc_q[REG_SIZE-1] ? -acc_q : acc_q;
      lead = '0;
      for (int unsigned k = 0; k < REG_SIZE; k++) if (mag[k]) lead = k;
      norm     = mag << (REG_SIZE - 1 - lead);
      guard    = norm[REG_SIZE-25];
      sticky   = |norm[REG_SIZE-26:0];
      rnd_up   = guard & (sticky | norm[REG_SIZE-24]);
      mant_rnd = {1'b0, norm[REG_SIZE-2:REG_SIZE-24]} + {23'b0, rnd_up};
      exp_n    = lead - 32'(FRAC_BITS) + 32'(BIAS) + {31'b0, mant_rnd[23]};
      out_d    = '0;
      ovf_d    = 1'b0;
      if (nan_q)                out_d = 32'h7FC0_0000;
      else if (!norm[REG_SIZE-1]) out_d = '0;
      else if (exp_n < 1)       out_d = {acc_q[REG_SIZE-1], 31'b0};
      else if (exp_n >= 255) begin
         out_d = {acc_q[REG_SIZE-1], 8'hFF, 23'b0};
         ovf_d = 1'b1;
      end else                  out_d = {acc_q[REG_SIZE-1], exp_n[7:0], mant_rnd[22:0]};
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         v1_q        <= 1'b0;
         first1_q    <= 1'b0;
         last1_q     <= 1'b0;
         v2_q        <= 1'b0;
         first2_q    <= 1'b0;
         last2_q     <= 1'b0;
         nan2_q      <= 1'b0;
         sum2_q      <= '0;
         acc_q       <= '0;
         nan_q       <= 1'b0;
         v3_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
      end else if (adv) begin
         v1_q        <= InValid;
         first1_q    <= InFirst;
         last1_q     <= InLast;
         v2_q        <= v1_q;
         first2_q    <= first1_q;
         last2_q     <= last1_q;
         nan2_q      <= |lane_nan;
         sum2_q      <= sum_d;
         acc_q       <= acc_d;
         nan_q       <= nan_d;
         v3_q        <= v2_q & last2_q;
         out_valid_q <= v3_q;
         if (v3_q) begin
            out_q <= out_d;
            ovf_q <= ovf_d;
         end
      end
   end

endmodule

// File: doc/multi_lane_exact_accumulator.md
MULTI_LANE_EXACT_ACCUMULATOR -- requirements
Module: multi_lane_exact_accumulator

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of FP32 product lanes per beat.
REQ-002 The block SHALL have parameter REG_WORDS, default 128, giving the accumulator width in words.
REQ-003 The block SHALL have parameter WORD_SIZE, default 8; REG_SIZE = REG_WORDS*WORD_SIZE and FRAC_BITS = REG_SIZE/2.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port InValid/InReady, input/output, 1 bit each: the input beat handshake.
REQ-007 The block SHALL have port InFirst/InLast, input, 1 bit each: frame start/end markers.
REQ-008 The block SHALL have port In1/In2, input, LANES*32 bits: IEEE-754 single-precision operands, lane i at [32i+31:32i].
REQ-009 The block SHALL have port LaneMask, input, LANES bits: 1 = lane contributes, 0 = lane contributes zero.
REQ-010 The block SHALL have port OutValid/OutReady, output/input, 1 bit each: the result handshake.
REQ-011 The block SHALL have port Out, output, 32 bits: the FP32 frame result.
REQ-012 The block SHALL have port OutOverflow, output, 1 bit: the result saturated to infinity.

Function
REQ-013 Beat transfer SHALL occur when InValid&&InReady; the global advance signal adv = !(OutValid&&!OutReady) and InReady = adv.
REQ-014 Pipeline SHALL be S1: per-lane exact product (sign, 9-bit exponent sum, 48-bit mantissa) registered; S2: each product aligned into a REG_SIZE two's-complement word, lanes summed, registered; S3: accumulator update; S4: normalised output register.
REQ-015 Alignment SHALL place a product at bit offset E1+E2-254-46+FRAC_BITS; accumulator bit k SHALL weigh 2^(k-FRAC_BITS); summation SHALL be exact (no rounding before S4).
REQ-016 Operands with exponent 0 (zero/denormal) SHALL contribute exact zero; masked lanes SHALL contribute zero.
REQ-017 A beat with InFirst SHALL load the accumulator with its lane sum; otherwise the lane sum SHALL be added to it.
REQ-018 A beat with InLast SHALL, one cycle after its S3 update, present the rounded result with OutValid=1; latency from an accepted InLast beat to OutValid SHALL be 4 cycles; InFirst&&InLast on one beat SHALL form a single-beat frame.
REQ-019 Normalisation SHALL take the sign from the accumulator MSB, the magnitude leading one at bit p, exponent = p-FRAC_BITS+127, and round-to-nearest-even on the 23-bit mantissa, including mantissa carry into the exponent.
REQ-020 A zero magnitude or exponent <1 SHALL give +0 / signed zero (flush); exponent >=255 SHALL give signed infinity with OutOverflow=1.
REQ-021 Any operand with exponent 255 in an unmasked lane SHALL set a sticky per-frame flag forcing Out=0x7FC00000, cleared by the next InFirst beat.
REQ-022 Out/OutOverflow SHALL hold stable while OutValid&&!OutReady; the pipeline SHALL stall entirely; back-to-back frames SHALL be accepted without bubbles when OutReady=1.
REQ-023 Beats without InFirst after reset SHALL accumulate onto zero.

Reset
REQ-024 Rst SHALL clear all stage valids, the accumulator, and the sticky flag, and set OutValid=0, Out=0, OutOverflow=0, InReady=1 (combinationally from OutValid=0).
REQ-025 Rst asserted mid-frame SHALL discard the partial frame; no result for it SHALL ever appear.

Structure
REQ-026 Package mac_pkg SHALL hold the FP32 field widths, BIAS=127, the product struct typedef (sign, exp[8:0], mant[47:0]) and the REG_SIZE/FRAC_BITS derivation function.
REQ-027 Per-lane multiply+align SHALL be sub-module fp_product_aligner, instantiated LANES times.

Verification
REQ-028 Single-beat frame, 4 lanes of 1.0*1.0 -> Out=0x40800000, OutValid exactly 4 cycles after acceptance.
REQ-029 Frame {2^60*1.0, 1.0*1.0, -2^60*1.0} over 3 beats -> Out=0x3F800000 (exact cancellation).
REQ-030 1.0+2^-24 -> 0x3F800000; 1.0+2^-23+2^-24 -> 0x3F800002 (RNE ties).
REQ-031 2^127*2^127 -> Out=0x7F800000, OutOverflow=1; next frame with a NaN operand -> 0x7FC00000, OutOverflow=0.
REQ-032 Two back-to-back frames with OutReady low 5 cycles -> first result held stable, InReady=0, second result correct and unduplicated; Rst mid-frame -> no output for that frame.
